// File: rtl/decoder_n_seq.sv
// Registered binary-to-one-hot decoder with level, timed-pulse and walking-one scan modes.
// All outputs come from a single state machine; out is never combinational from sel.
module decoder_n_seq #(
  parameter  int SEL_W     = 2,
  parameter  int PULSE_LEN = 4,
  parameter  int CNT_W     = 8,
  localparam int OUTS      = 2**SEL_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic             load,
  input  logic [SEL_W-1:0] sel,
  output logic [0:OUTS-1]  out,
  output logic             busy,
  output logic             done
);

  // One counter serves both the pulse length and the scan step count.
  localparam int CW = (CNT_W > SEL_W) ? CNT_W : SEL_W;
  localparam logic [CW-1:0] PULSE_INIT = CW'(PULSE_LEN - 1);
  localparam logic [CW-1:0] SCAN_INIT  = CW'(OUTS - 1);

  localparam logic [1:0] MODE_LEVEL = 2'b00;
  localparam logic [1:0] MODE_PULSE = 2'b01;
  localparam logic [1:0] MODE_SCAN  = 2'b10;

  typedef enum logic [1:0] {IDLE, PULSE, SCAN} state_t;

  state_t           state_reg;
  logic [CW-1:0]    cnt_reg;
  logic [SEL_W-1:0] idx_reg;
  logic [SEL_W-1:0] idx_next;
  logic [0:OUTS-1]  sel_hot;
  logic [0:OUTS-1]  next_hot;

  // Wrap from OUTS-1 to 0 falls out of SEL_W-bit overflow.
  assign idx_next = idx_reg + SEL_W'(1);

  genvar gi;
  generate
    for (gi = 0; gi < OUTS; gi++) begin : g_hot
      assign sel_hot[gi]  = (sel == SEL_W'(gi));
      assign next_hot[gi] = (idx_next == SEL_W'(gi));
    end
  endgenerate

  always_ff @(posedge clk) begin
    done <= 1'b0;
    if (rst) begin
      state_reg <= IDLE;
      out       <= '0;
      busy      <= 1'b0;
      cnt_reg   <= '0;
      idx_reg   <= '0;
    end else if (!en) begin
      state_reg <= IDLE;
      out       <= '0;
      busy      <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          busy <= 1'b0;
          case (mode)
            MODE_LEVEL: out <= sel_hot;
            MODE_PULSE: begin
              if (load) begin
                out       <= sel_hot;
                cnt_reg   <= PULSE_INIT;
                state_reg <= PULSE;
                busy      <= 1'b1;
              end else begin
                out <= '0;
              end
            end
            MODE_SCAN: begin
              if (load) begin
                idx_reg   <= sel;
                out       <= sel_hot;
                cnt_reg   <= SCAN_INIT;
                state_reg <= SCAN;
                busy      <= 1'b1;
              end else begin
                out <= '0;
              end
            end
            default: out <= '0;
          endcase
        end

        PULSE: begin
          if (mode != MODE_PULSE) begin
            state_reg <= IDLE;
            out       <= '0;
            busy      <= 1'b0;
          end else if (cnt_reg != '0) begin
            cnt_reg <= cnt_reg - CW'(1);
          end else begin
            state_reg <= IDLE;
            out       <= '0;
            busy      <= 1'b0;
            done      <= 1'b1;
          end
        end

        SCAN: begin
          if (mode != MODE_SCAN) begin
            state_reg <= IDLE;
            out       <= '0;
            busy      <= 1'b0;
          end else if (cnt_reg != '0) begin
            idx_reg <= idx_next;
            out     <= next_hot;
            cnt_reg <= cnt_reg - CW'(1);
          end else begin
            state_reg <= IDLE;
            out       <= '0;
            busy      <= 1'b0;
            done      <= 1'b1;
          end
        end

        default: begin
          state_reg <= IDLE;
          out       <= '0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_decoder_n_seq.sv
// Table-driven bench for decoder_n_seq: a 2-bit/PULSE_LEN=4 instance driven from a vector table
// and a 3-bit/PULSE_LEN=1 instance exercised with hand-written sequences.
module tb_decoder_n_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // 2-bit select instance
  logic       rst, en, load;
  logic [1:0] mode, sel;
  logic [0:3] out;
  logic       busy, done;

  // 3-bit select instance
  logic       rst3, en3, load3;
  logic [1:0] mode3;
  logic [2:0] sel3;
  logic [0:7] out3;
  logic       busy3, done3;

  decoder_n_seq #(.SEL_W(2), .PULSE_LEN(4), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .load(load), .sel(sel),
    .out(out), .busy(busy), .done(done)
  );

  decoder_n_seq #(.SEL_W(3), .PULSE_LEN(1), .CNT_W(8)) dut3 (
    .clk(clk), .rst(rst3), .en(en3), .mode(mode3), .load(load3), .sel(sel3),
    .out(out3), .busy(busy3), .done(done3)
  );

  typedef struct {
    logic       rst;
    logic       en;
    logic [1:0] mode;
    logic       load;
    logic [1:0] sel;
    logic [0:3] eout;
    logic       ebusy;
    logic       edone;
  } vec_t;

  vec_t vecs[$];
  int   checks   = 0;
  int   failures = 0;

  task automatic add(input logic r, input logic e, input logic [1:0] m, input logic l,
                     input logic [1:0] s, input logic [0:3] eo, input logic eb, input logic ed);
    vec_t v;
    v.rst = r; v.en = e; v.mode = m; v.load = l; v.sel = s;
    v.eout = eo; v.ebusy = eb; v.edone = ed;
    vecs.push_back(v);
  endtask

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%b required=%b", nm, act, exp);
    end
  endtask

  function automatic logic [0:7] hot8(input int idx);
    logic [0:7] v;
    v = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

  task automatic step3(input string nm, input logic [0:7] eo, input logic eb, input logic ed);
    @(posedge clk); #1;
    chk({nm, ".out"}, out3, eo);
    chk({nm, ".busy"}, {7'd0, busy3}, {7'd0, eb});
    chk({nm, ".done"}, {7'd0, done3}, {7'd0, ed});
    $display("dut3 %s out=%b busy=%b done=%b", nm, out3, busy3, done3);
  endtask

  initial begin
    // rst en mode load sel -> out busy done
    // Reset then level decode
    add(1, 0, 2'b00, 0, 2'd0, 4'b0000, 0, 0);
    add(1, 0, 2'b00, 0, 2'd0, 4'b0000, 0, 0);
    add(0, 1, 2'b00, 0, 2'd0, 4'b1000, 0, 0);
    add(0, 1, 2'b00, 0, 2'd1, 4'b0100, 0, 0);
    add(0, 1, 2'b00, 1, 2'd2, 4'b0010, 0, 0);
    add(0, 1, 2'b00, 0, 2'd3, 4'b0001, 0, 0);
    add(0, 0, 2'b00, 0, 2'd3, 4'b0000, 0, 0);
    // Pulse sel=2, sel toggles and re-load ignored, done-cycle load ignored
    add(0, 1, 2'b01, 1, 2'd2, 4'b0010, 1, 0);
    add(0, 1, 2'b01, 0, 2'd1, 4'b0010, 1, 0);
    add(0, 1, 2'b01, 1, 2'd3, 4'b0010, 1, 0);
    add(0, 1, 2'b01, 0, 2'd0, 4'b0010, 1, 0);
    add(0, 1, 2'b01, 1, 2'd1, 4'b0000, 0, 1);
    add(0, 1, 2'b01, 0, 2'd1, 4'b0000, 0, 0);
    // New pulse sel=1, aborted by en=0 after 2 cycles
    add(0, 1, 2'b01, 1, 2'd1, 4'b0100, 1, 0);
    add(0, 1, 2'b01, 0, 2'd1, 4'b0100, 1, 0);
    add(0, 0, 2'b01, 0, 2'd1, 4'b0000, 0, 0);
    add(0, 0, 2'b01, 0, 2'd1, 4'b0000, 0, 0);
    // Scan from 3 with wrap
    add(0, 1, 2'b10, 1, 2'd3, 4'b0001, 1, 0);
    add(0, 1, 2'b10, 0, 2'd0, 4'b1000, 1, 0);
    add(0, 1, 2'b10, 1, 2'd0, 4'b0100, 1, 0);
    add(0, 1, 2'b10, 0, 2'd0, 4'b0010, 1, 0);
    add(0, 1, 2'b10, 0, 2'd0, 4'b0000, 0, 1);
    add(0, 1, 2'b10, 0, 2'd0, 4'b0000, 0, 0);
    // Pulse aborted by mode change 01 -> 10
    add(0, 1, 2'b01, 1, 2'd1, 4'b0100, 1, 0);
    add(0, 1, 2'b01, 0, 2'd1, 4'b0100, 1, 0);
    add(0, 1, 2'b10, 0, 2'd1, 4'b0000, 0, 0);
    add(0, 1, 2'b10, 0, 2'd0, 4'b0000, 0, 0);
    // Scan aborted by reset
    add(0, 1, 2'b10, 1, 2'd0, 4'b1000, 1, 0);
    add(0, 1, 2'b10, 0, 2'd0, 4'b0100, 1, 0);
    add(1, 1, 2'b10, 0, 2'd0, 4'b0000, 0, 0);
    add(0, 1, 2'b10, 0, 2'd0, 4'b0000, 0, 0);
    // Reserved mode with load
    add(0, 1, 2'b11, 1, 2'd2, 4'b0000, 0, 0);
    add(0, 1, 2'b11, 0, 2'd1, 4'b0000, 0, 0);

    rst3 = 1'b1; en3 = 1'b0; mode3 = 2'b00; load3 = 1'b0; sel3 = 3'd0;

    for (int i = 0; i < vecs.size(); i++) begin
      rst = vecs[i].rst; en = vecs[i].en; mode = vecs[i].mode;
      load = vecs[i].load; sel = vecs[i].sel;
      @(posedge clk); #1;
      chk($sformatf("v%0d.out", i), {4'd0, out}, {4'd0, vecs[i].eout});
      chk($sformatf("v%0d.busy", i), {7'd0, busy}, {7'd0, vecs[i].ebusy});
      chk($sformatf("v%0d.done", i), {7'd0, done}, {7'd0, vecs[i].edone});
      $display("dut v%0d rst=%b en=%b mode=%b load=%b sel=%0d out=%b busy=%b done=%b",
               i, rst, en, mode, load, sel, out, busy, done);
    end

    // SEL_W=3 scan from 6 visits 6,7,0..5 then done
    rst3 = 1'b0; en3 = 1'b1; mode3 = 2'b10; load3 = 1'b1; sel3 = 3'd6;
    step3("scan0", hot8(6), 1, 0);
    load3 = 1'b0; sel3 = 3'd2;
    for (int k = 1; k < 8; k++)
      step3($sformatf("scan%0d", k), hot8((6 + k) % 8), 1, 0);
    step3("scan_done", 8'b0, 0, 1);
    step3("scan_idle", 8'b0, 0, 0);

    // PULSE_LEN=1 single-cycle strobe on out[5]
    mode3 = 2'b01; load3 = 1'b1; sel3 = 3'd5;
    step3("pulse1", hot8(5), 1, 0);
    load3 = 1'b0;
    step3("pulse1_done", 8'b0, 0, 1);
    step3("pulse1_idle", 8'b0, 0, 0);

    // Reserved mode keeps out at zero
    mode3 = 2'b11;
    for (int k = 0; k < 3; k++) begin
      load3 = 1'b1; sel3 = 3'(k + 3);
      step3($sformatf("m11_%0d", k), 8'b0, 0, 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
